// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronises N sources, latches edge/level requests, masks them and
// presents the lowest-index request to the core through a req/ack handshake.
module irq_ctrl #(
    parameter int unsigned         NUM_IRQ     = 5,
    parameter int unsigned         SYNC_STAGES = 2,
    parameter logic [NUM_IRQ-1:0]  EDGE_MODE   = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               mask_we,
    input  logic [NUM_IRQ-1:0] mask_wdata,
    input  logic               ack,
    input  logic [4:0]         ack_id,
    output logic [NUM_IRQ-1:0] mask,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] overrun,
    output logic [NUM_IRQ-1:0] interrupts,
    output logic               irq_req,
    output logic [4:0]         irq_id
);

    localparam logic StIdle = 1'b0;
    localparam logic StReq  = 1'b1;

    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0] sync_s;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] req_vec;
    logic [NUM_IRQ-1:0] pending_q, pending_d;
    logic [NUM_IRQ-1:0] overrun_q, overrun_d;
    logic [NUM_IRQ-1:0] mask_q, mask_d;
    logic [NUM_IRQ-1:0] interrupts_q;
    logic               state_q, state_d;
    logic [4:0]         irq_id_q, irq_id_d;
    logic [4:0]         lowest_id;
    logic               ack_accept;

    assign sync_s  = sync_q[SYNC_STAGES-1];
    assign rise    = sync_s & ~prev_q & EDGE_MODE;
    assign req_vec = pending_q & mask_q;

    // irq_id_q is always a valid channel while in REQ, so out-of-range ack_id never matches.
    assign ack_accept = ack && (state_q == StReq) && (ack_id == irq_id_q);
    assign clr        = ack_accept ? (NUM_IRQ'(1) << irq_id_q) : '0;

    always_comb begin
        lowest_id = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_vec[i]) lowest_id = 5'(i);
        end
    end

    // A rise coinciding with the clearing ack keeps the channel pending and leaves overrun alone.
    always_comb begin
        pending_d = pending_q;
        overrun_d = overrun_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            if (EDGE_MODE[i]) begin
                if (rise[i]) begin
                    pending_d[i] = 1'b1;
                    if (!clr[i] && pending_q[i]) overrun_d[i] = 1'b1;
                end else if (clr[i]) begin
                    pending_d[i] = 1'b0;
                    overrun_d[i] = 1'b0;
                end
            end else begin
                pending_d[i] = sync_s[i];
                overrun_d[i] = 1'b0;
            end
        end
    end

    assign mask_d = mask_we ? mask_wdata : mask_q;

    always_comb begin
        state_d  = state_q;
        irq_id_d = irq_id_q;
        case (state_q)
            StIdle: begin
                if (|req_vec) begin
                    state_d  = StReq;
                    irq_id_d = lowest_id;
                end
            end
            StReq: begin
                if (ack_accept) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q       <= '0;
            prev_q       <= '0;
            pending_q    <= '0;
            overrun_q    <= '0;
            mask_q       <= '1;
            interrupts_q <= '0;
            state_q      <= StIdle;
            irq_id_q     <= '0;
        end else begin
            sync_q       <= {sync_q[SYNC_STAGES-2:0], irq_in};
            prev_q       <= sync_s;
            pending_q    <= pending_d;
            overrun_q    <= overrun_d;
            mask_q       <= mask_d;
            interrupts_q <= pending_q & mask_q;
            state_q      <= state_d;
            irq_id_q     <= irq_id_d;
        end
    end

    assign mask       = mask_q;
    assign pending    = pending_q;
    assign overrun    = overrun_q;
    assign interrupts = interrupts_q;
    assign irq_req    = (state_q == StReq);
    assign irq_id     = irq_id_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios plus random traffic, scored against a reference model.
module tb_irq_ctrl;

    localparam int         N    = 5;
    localparam int         SS   = 2;
    localparam logic [4:0] EDGE = 5'b01110;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] irq_in, mask_wdata, ack_id;
    logic       mask_we, ack;
    logic [4:0] mask, pending, overrun, interrupts, irq_id;
    logic       irq_req;

    irq_ctrl #(.NUM_IRQ(N), .SYNC_STAGES(SS), .EDGE_MODE(EDGE)) dut (
        .clk(clk), .rst(rst), .irq_in(irq_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
        .ack(ack), .ack_id(ack_id), .mask(mask), .pending(pending), .overrun(overrun),
        .interrupts(interrupts), .irq_req(irq_req), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] pend;
        logic [4:0] ovr;
        logic [4:0] msk;
        logic [4:0] intr;
        logic       req;
        logic [4:0] id;
    } snap_t;

    snap_t      exp_q[$];
    logic [4:0] req_q[$];
    int         tests = 0;
    int         fails = 0;

    // Reference model state
    logic [4:0] hist[SS];
    logic [4:0] m_prev, m_pend, m_ovr, m_mask, m_intr, m_id;
    logic       m_req;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < SS; k++) hist[k] = '0;
        m_prev = '0; m_pend = '0; m_ovr = '0; m_mask = 5'h1f; m_intr = '0;
        m_req = 1'b0; m_id = '0;
    endfunction

    function automatic void model_step(input logic [4:0] irq, input logic we,
                                       input logic [4:0] wd, input logic a,
                                       input logic [4:0] aid);
        logic [4:0] s, np, no;
        bit         acc, edge_now, cleared;
        int         lo;
        snap_t      e;
        s   = hist[SS-1];
        acc = a && m_req && (int'(aid) == int'(m_id));
        np  = m_pend;
        no  = m_ovr;
        for (int i = 0; i < N; i++) begin
            if (!EDGE[i]) begin
                np[i] = s[i];
                no[i] = 1'b0;
            end else begin
                edge_now = s[i] && !m_prev[i];
                cleared  = acc && (int'(m_id) == i);
                if (edge_now) begin
                    if (!cleared && m_pend[i]) no[i] = 1'b1;
                    np[i] = 1'b1;
                end else if (cleared) begin
                    np[i] = 1'b0;
                    no[i] = 1'b0;
                end
            end
        end
        if (!m_req) begin
            lo = -1;
            for (int i = 0; i < N; i++) if (m_pend[i] && m_mask[i] && lo < 0) lo = i;
            if (lo >= 0) begin
                m_req = 1'b1;
                m_id  = 5'(lo);
                req_q.push_back(m_id);
            end
        end else if (acc) begin
            m_req = 1'b0;
        end
        m_intr = m_pend & m_mask;
        if (we) m_mask = wd;
        m_prev = s;
        for (int k = SS - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = irq;
        m_pend = np;
        m_ovr  = no;
        e.pend = m_pend; e.ovr = m_ovr; e.msk = m_mask; e.intr = m_intr;
        e.req = m_req; e.id = m_id;
        exp_q.push_back(e);
    endfunction

    task automatic cycle(input logic [4:0] irq, input logic we = 1'b0,
                         input logic [4:0] wd = 5'h0, input logic a = 1'b0,
                         input logic [4:0] aid = 5'h0);
        irq_in = irq; mask_we = we; mask_wdata = wd; ack = a; ack_id = aid;
        @(posedge clk);
        model_step(irq, we, wd, a, aid);
        @(negedge clk);
    endtask

    task automatic idle_cycles(input logic [4:0] irq, input int n);
        for (int k = 0; k < n; k++) cycle(irq);
    endtask

    // Monitor: scores every cycle's outputs and every new request against the model.
    initial begin : monitor
        snap_t e;
        logic  req_prev;
        req_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                req_prev = 1'b0;
            end else begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("pending", pending, e.pend);
                    chk("overrun", overrun, e.ovr);
                    chk("mask", mask, e.msk);
                    chk("interrupts", interrupts, e.intr);
                    chk("irq_req", irq_req, e.req);
                    chk("irq_id", irq_id, e.id);
                end
                if (irq_req && !req_prev) begin
                    if (req_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL req_event: irq_req rose with id %0d, none expected", irq_id);
                    end else begin
                        chk("req_event_id", irq_id, req_q.pop_front());
                    end
                end
                req_prev = irq_req;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [4:0] irq, wd, aid;
        logic       we, a;
        rst = 1'b1;
        irq_in = '0; mask_we = 1'b0; mask_wdata = '0; ack = 1'b0; ack_id = '0;
        model_reset();
        #11;
        chk("rst_pending", pending, 5'h00);
        chk("rst_mask", mask, 5'h1f);
        chk("rst_req", irq_req, 1'b0);
        #1 rst = 1'b0;

        // Single edge on ch2: pending after edge 3, request after edge 4
        cycle(5'h04); cycle(5'h04);
        chk("t2_pend_e2", pending, 5'h00);
        cycle(5'h04);
        chk("t2_pend_e3", pending, 5'h04);
        chk("t2_req_e3", irq_req, 1'b0);
        cycle(5'h04);
        chk("t2_req_e4", irq_req, 1'b1);
        chk("t2_id_e4", irq_id, 5'd2);
        cycle(5'h04, 1'b0, 5'h0, 1'b1, 5'd2);
        chk("t2_pend_ack", pending, 5'h00);
        chk("t2_req_ack", irq_req, 1'b0);
        idle_cycles(5'h00, 3);

        // Ch1 and ch3 together, ch0 level arriving during REQ
        idle_cycles(5'h0a, 4);
        chk("t3_id_first", irq_id, 5'd1);
        idle_cycles(5'h0b, 3);
        chk("t3_pend_ch0", pending, 5'h0b);
        chk("t3_id_frozen", irq_id, 5'd1);
        idle_cycles(5'h0a, 3);
        cycle(5'h0a, 1'b0, 5'h0, 1'b1, 5'd1);
        chk("t3_req_gap", irq_req, 1'b0);
        cycle(5'h0a);
        chk("t3_req_second", irq_req, 1'b1);
        chk("t3_id_second", irq_id, 5'd3);

        // Ignored acks: out of range, wrong id, and in IDLE
        cycle(5'h0a, 1'b0, 5'h0, 1'b1, 5'd7);
        chk("t6_oob_req", irq_req, 1'b1);
        chk("t6_oob_pend", pending, 5'h08);
        cycle(5'h0a, 1'b0, 5'h0, 1'b1, 5'd1);
        chk("t6_wrong_id", irq_id, 5'd3);
        chk("t6_wrong_req", irq_req, 1'b1);
        cycle(5'h0a, 1'b0, 5'h0, 1'b1, 5'd3);
        cycle(5'h0a, 1'b0, 5'h0, 1'b1, 5'd3);
        chk("t6_idle_req", irq_req, 1'b0);
        chk("t6_idle_pend", pending, 5'h00);
        idle_cycles(5'h00, 3);

        // Overrun on ch2, rise coinciding with ack
        idle_cycles(5'h04, 4);
        idle_cycles(5'h00, 3);
        idle_cycles(5'h04, 3);
        chk("t4_overrun", overrun, 5'h04);
        idle_cycles(5'h00, 3);
        cycle(5'h04); cycle(5'h04);
        cycle(5'h04, 1'b0, 5'h0, 1'b1, 5'd2);
        chk("t4_coincide_pend", pending, 5'h04);
        chk("t4_coincide_ovr", overrun, 5'h04);
        chk("t4_coincide_req", irq_req, 1'b0);
        cycle(5'h04);
        chk("t4_rereq", irq_req, 1'b1);
        cycle(5'h04, 1'b0, 5'h0, 1'b1, 5'd2);
        chk("t4_clr_pend", pending, 5'h00);
        chk("t4_clr_ovr", overrun, 5'h00);
        idle_cycles(5'h00, 3);

        // Masked level ch0
        cycle(5'h00, 1'b1, 5'h1e);
        idle_cycles(5'h01, 4);
        chk("t5_pend", pending, 5'h01);
        chk("t5_intr", interrupts, 5'h00);
        chk("t5_req", irq_req, 1'b0);
        cycle(5'h01, 1'b1, 5'h1f);
        chk("t5_unmask_req0", irq_req, 1'b0);
        cycle(5'h01);
        chk("t5_unmask_req1", irq_req, 1'b1);
        chk("t5_unmask_id", irq_id, 5'd0);
        idle_cycles(5'h00, 3);
        chk("t5_level_drop_req", irq_req, 1'b1);
        cycle(5'h00, 1'b0, 5'h0, 1'b1, 5'd0);
        chk("t5_ack", irq_req, 1'b0);

        // Async reset in the middle of a request
        idle_cycles(5'h10, 4);
        chk("t1_pre_req", irq_req, 1'b1);
        #2 rst = 1'b1;
        irq_in = '0; ack = 1'b0; mask_we = 1'b0;
        #1;
        chk("t1_req", irq_req, 1'b0);
        chk("t1_id", irq_id, 5'd0);
        chk("t1_pend", pending, 5'h00);
        chk("t1_intr", interrupts, 5'h00);
        chk("t1_mask", mask, 5'h1f);
        exp_q.delete();
        req_q.delete();
        model_reset();
        #19 rst = 1'b0;

        // Random traffic
        irq = '0;
        for (int n = 0; n < 1500; n++) begin
            we = 1'b0; wd = '0; a = 1'b0; aid = '0;
            for (int b = 0; b < N; b++) if ($urandom_range(0, 7) == 0) irq[b] = ~irq[b];
            if ($urandom_range(0, 15) == 0) begin
                we = 1'b1;
                wd = 5'($urandom) | 5'($urandom);
            end
            if (m_req && $urandom_range(0, 3) == 0) begin
                a   = 1'b1;
                aid = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 7)) : m_id;
            end else if ($urandom_range(0, 15) == 0) begin
                a   = 1'b1;
                aid = 5'($urandom_range(0, 7));
            end
            cycle(irq, we, wd, a, aid);
        end
        idle_cycles(5'h00, 5);
        #1;
        chk("drain_req_events", req_q.size(), 0);
        chk("drain_snapshots", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
